hadamard4_inverse_seq: RTL

//  Inverse 4-point Hadamard transform: recovers x0..x3 from coefficients y0..y3

---
 rtl/hadamard4_inverse_seq_if.sv | 32 +++
 rtl/hadamard4_inverse_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hadamard4_inverse_seq_if.sv
// Handshake bundle for the inverse 4-point Hadamard engine.
// The slave modport is the transform's view and the master modport is the
// view of the producer/consumer pair driving it.
interface hadamard4_inverse_seq_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  y0;
  logic signed [IN_W-1:0]  y1;
  logic signed [IN_W-1:0]  y2;
  logic signed [IN_W-1:0]  y3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] x0;
  logic signed [OUT_W-1:0] x1;
  logic signed [OUT_W-1:0] x2;
  logic signed [OUT_W-1:0] x3;
  logic                    inexact;
  logic                    sat;

  modport master (
    output in_valid, y0, y1, y2, y3, out_ready,
    input  in_ready, out_valid, x0, x1, x2, x3, inexact, sat
  );

  modport slave (
    input  in_valid, y0, y1, y2, y3, out_ready,
    output in_ready, out_valid, x0, x1, x2, x3, inexact, sat
  );
endinterface

// File: rtl/hadamard4_inverse_seq.sv
// Inverse 4-point Hadamard transform, x = (H4 * y) / 4 in natural row order.
// One register bank is reused: it holds the sign-extended inputs, then the
// first butterfly results, then the second butterfly sums, before the
// scale/saturate stage writes the output registers.
module hadamard4_inverse_seq #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  hadamard4_inverse_seq_if.slave bus
);
  localparam int W    = IN_W + 2;
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [W-1:0] MAXV = W'(MAXI);
  localparam logic signed [W-1:0] MINV = W'(-MAXI - 1);

  typedef enum logic [2:0] {IDLE, BF1, BF2, SCALE, HOLD} state_t;

  state_t                  state;
  state_t                  state_next;
  logic signed [W-1:0]     r       [4];
  logic signed [W-1:0]     bf1     [4];
  logic signed [W-1:0]     bf2     [4];
  logic signed [W-1:0]     shifted [4];
  logic signed [OUT_W-1:0] xclip   [4];
  logic signed [OUT_W-1:0] xq      [4];
  logic                    inexact_next;
  logic                    sat_next;
  logic                    inexact_q;
  logic                    sat_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: fixed walk through the pipeline, HOLD waits for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = BF1;
      BF1:     state_next = BF2;
      BF2:     state_next = SCALE;
      SCALE:   state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both butterfly stages computed from the shared register bank
  always_comb begin
    bf1[0] = r[0] + r[1];
    bf1[1] = r[0] - r[1];
    bf1[2] = r[2] + r[3];
    bf1[3] = r[2] - r[3];
    bf2[0] = r[0] + r[2];
    bf2[1] = r[1] + r[3];
    bf2[2] = r[0] - r[2];
    bf2[3] = r[1] - r[3];
  end

  // Divide by four with floor rounding, clip to the output range, collect flags
  always_comb begin
    inexact_next = 1'b0;
    sat_next     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shifted[i] = r[i] >>> 2;
      xclip[i]   = OUT_W'(shifted[i]);
      if (shifted[i] > MAXV) begin
        xclip[i] = OUT_W'(MAXV);
        sat_next = 1'b1;
      end else if (shifted[i] < MINV) begin
        xclip[i] = OUT_W'(MINV);
        sat_next = 1'b1;
      end
      if (r[i][1:0] != 2'b00) inexact_next = 1'b1;
    end
  end

  // Datapath registers: load, two butterfly passes, then the registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r[i]  <= '0;
        xq[i] <= '0;
      end
      inexact_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r[0] <= W'(bus.y0);
            r[1] <= W'(bus.y1);
            r[2] <= W'(bus.y2);
            r[3] <= W'(bus.y3);
          end
        end
        BF1: begin
          for (int i = 0; i < 4; i++) r[i] <= bf1[i];
        end
        BF2: begin
          for (int i = 0; i < 4; i++) r[i] <= bf2[i];
        end
        SCALE: begin
          for (int i = 0; i < 4; i++) xq[i] <= xclip[i];
          inexact_q <= inexact_next;
          sat_q     <= sat_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.x0        = xq[0];
  assign bus.x1        = xq[1];
  assign bus.x2        = xq[2];
  assign bus.x3        = xq[3];
  assign bus.inexact   = inexact_q;
  assign bus.sat       = sat_q;
endmodule
